// File: rtl/round_enum_pkg.sv
// Shared types and constants for the binary32 multiplier.
// Also holds the behavioural reference product used for on-chip self-checking.
package round_enum_pkg;

    typedef enum logic [2:0] {
        IEEE_near = 3'd0,
        IEEE_zero = 3'd1,
        IEEE_pinf = 3'd2,
        IEEE_ninf = 3'd3,
        near_up   = 3'd4,
        away_zero = 3'd5
    } round_values;

    localparam int ST_ZERO    = 0;
    localparam int ST_INF     = 1;
    localparam int ST_NAN     = 2;
    localparam int ST_TINY    = 3;
    localparam int ST_HUGE    = 4;
    localparam int ST_INEXACT = 5;

    localparam int          BIAS         = 127;
    localparam logic [31:0] CANON_NAN    = 32'h7FC0_0000;
    localparam logic [30:0] INF_MAG      = 31'h7F80_0000;
    localparam logic [30:0] MAX_NORM_MAG = 31'h7F7F_FFFF;
    localparam logic [30:0] MIN_NORM_MAG = 31'h0080_0000;

    function automatic logic [31:0] fp_mult_ref(input logic [31:0] a,
                                                 input logic [31:0] b,
                                                 input round_values mode);
        logic        sgn;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [47:0] p;
        logic [23:0] m;
        logic [24:0] mr;
        logic        g, s, up;
        int          e;
        round_values md;

        sgn    = a[31] ^ b[31];
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);

        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            return CANON_NAN;
        if (a_inf || b_inf)
            return {sgn, INF_MAG};
        if (a_zero || b_zero)
            return {sgn, 31'd0};

        md = (mode > away_zero) ? IEEE_near : mode;
        p  = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e  = int'(a[30:23]) + int'(b[30:23]) - BIAS;
        if (p[47]) begin
            m = p[47:24];
            g = p[23];
            s = |p[22:0];
            e = e + 1;
        end else begin
            m = p[46:23];
            g = p[22];
            s = |p[21:0];
        end

        case (md)
            IEEE_near: up = g && (s || m[0]);
            IEEE_zero: up = 1'b0;
            IEEE_pinf: up = !sgn && (g || s);
            IEEE_ninf: up = sgn && (g || s);
            near_up:   up = g && (s || !sgn);
            default:   up = g || s;
        endcase

        mr = {1'b0, m} + {24'd0, up};
        if (mr[24]) begin
            m = mr[24:1];
            e = e + 1;
        end else begin
            m = mr[23:0];
        end

        if (e >= 255)
            return ((md == IEEE_zero) || (md == IEEE_pinf && sgn) || (md == IEEE_ninf && !sgn))
                   ? {sgn, MAX_NORM_MAG} : {sgn, INF_MAG};
        if (e <= 0)
            return ((md == away_zero) || (md == IEEE_pinf && !sgn) || (md == IEEE_ninf && sgn))
                   ? {sgn, MIN_NORM_MAG} : {sgn, 31'd0};
        // (e-1)<<23 plus the mantissa with its hidden bit yields e<<23 plus the fraction
        return {sgn, 31'((e - 1) * 8388608 + int'(m))};
    endfunction

endpackage

// File: rtl/fp_round.sv
// Rounds a normalized 24-bit mantissa by mode, renormalizing on carry-out.
// Purely combinational; no flow control.
module fp_round
    import round_enum_pkg::*;
(
    input  logic              sign,
    input  logic [23:0]       mant,
    input  logic              guard,
    input  logic              sticky,
    input  logic signed [9:0] exp_in,
    input  round_values       mode,
    output logic [22:0]       frac_o,
    output logic signed [9:0] exp_o,
    output logic              inexact
);

    logic        inc;
    logic [24:0] sum;

    always_comb begin
        inexact = guard | sticky;
        inc     = 1'b0;
        case (mode)
            IEEE_zero: inc = 1'b0;
            IEEE_pinf: inc = ~sign & inexact;
            IEEE_ninf: inc = sign & inexact;
            near_up:   inc = guard & (sticky | ~sign);
            away_zero: inc = inexact;
            default:   inc = guard & (sticky | mant[0]);
        endcase

        sum = {1'b0, mant} + {24'd0, inc};
        if (sum[24]) begin
            frac_o = sum[23:1];
            exp_o  = exp_in + 10'sd1;
        end else begin
            frac_o = sum[22:0];
            exp_o  = exp_in;
        end
    end

endmodule

// File: rtl/fp_mult_top.sv
// Binary32 multiplier: registered operands, mode-selectable rounding, exception flags.
// Latency 2 clocks, one operation per clock; no handshake, never stalls.
module fp_mult_top
    import round_enum_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  round_values round,
    output logic [31:0] z,
    output logic [7:0]  status,
    output logic [31:0] z_function_out
);

    logic [31:0] a_d, a_q, b_d, b_q;
    round_values round_d, round_q;
    logic        vld_d, vld_q;
    logic [31:0] z_d, z_q, zf_d, zf_q;
    logic [7:0]  status_d, status_q;

    logic [7:0]        ea, eb;
    logic              sign;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0]       prod;
    logic signed [9:0] exp_raw, exp_norm, exp_rnd;
    logic [23:0]       mant_norm;
    logic              guard, sticky, inexact;
    logic [22:0]       frac_rnd;
    logic              ovf_to_inf, unf_to_min;

    always_comb begin
        a_d     = a;
        b_d     = b;
        round_d = round;
        vld_d   = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            round_q <= IEEE_near;
            vld_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            round_q <= round_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        ea     = a_q[30:23];
        eb     = b_q[30:23];
        sign   = a_q[31] ^ b_q[31];
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
        b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
        a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
        b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);

        prod    = {24'd0, 1'b1, a_q[22:0]} * {24'd0, 1'b1, b_q[22:0]};
        exp_raw = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'(BIAS);

        // Product of two [1,2) mantissas lies in [1,4); bit 47 flags the [2,4) half
        if (prod[47]) begin
            mant_norm = prod[47:24];
            guard     = prod[23];
            sticky    = |prod[22:0];
            exp_norm  = exp_raw + 10'sd1;
        end else begin
            mant_norm = prod[46:23];
            guard     = prod[22];
            sticky    = |prod[21:0];
            exp_norm  = exp_raw;
        end
    end

    fp_round u_round (
        .sign    (sign),
        .mant    (mant_norm),
        .guard   (guard),
        .sticky  (sticky),
        .exp_in  (exp_norm),
        .mode    (round_q),
        .frac_o  (frac_rnd),
        .exp_o   (exp_rnd),
        .inexact (inexact)
    );

    always_comb begin
        case (round_q)
            IEEE_zero: ovf_to_inf = 1'b0;
            IEEE_pinf: ovf_to_inf = ~sign;
            IEEE_ninf: ovf_to_inf = sign;
            default:   ovf_to_inf = 1'b1;
        endcase
        case (round_q)
            away_zero: unf_to_min = 1'b1;
            IEEE_pinf: unf_to_min = ~sign;
            IEEE_ninf: unf_to_min = sign;
            default:   unf_to_min = 1'b0;
        endcase
    end

    always_comb begin
        z_d      = '0;
        status_d = '0;
        zf_d     = '0;
        if (vld_q) begin
            zf_d = fp_mult_ref(a_q, b_q, round_q);
            if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
                z_d              = CANON_NAN;
                status_d[ST_NAN] = 1'b1;
            end else if (a_inf || b_inf) begin
                z_d              = {sign, INF_MAG};
                status_d[ST_INF] = 1'b1;
            end else if (a_zero || b_zero) begin
                z_d               = {sign, 31'd0};
                status_d[ST_ZERO] = 1'b1;
            end else if (exp_rnd >= 10'sd255) begin
                status_d[ST_HUGE]    = 1'b1;
                status_d[ST_INEXACT] = 1'b1;
                status_d[ST_INF]     = ovf_to_inf;
                z_d = ovf_to_inf ? {sign, INF_MAG} : {sign, MAX_NORM_MAG};
            end else if (exp_rnd <= 10'sd0) begin
                status_d[ST_TINY]    = 1'b1;
                status_d[ST_INEXACT] = 1'b1;
                status_d[ST_ZERO]    = ~unf_to_min;
                z_d = unf_to_min ? {sign, MIN_NORM_MAG} : {sign, 31'd0};
            end else begin
                z_d                  = {sign, exp_rnd[7:0], frac_rnd};
                status_d[ST_INEXACT] = inexact;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z_q      <= '0;
            status_q <= '0;
            zf_q     <= '0;
        end else begin
            z_q      <= z_d;
            status_q <= status_d;
            zf_q     <= zf_d;
        end
    end

    assign z              = z_q;
    assign status         = status_q;
    assign z_function_out = zf_q;

endmodule

// File: tb/tb_fp_mult_top.sv
// Bench for fp_mult_top: arithmetic reference model plus literal spot checks.
module tb_fp_mult_top;
    import round_enum_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    round_values round;
    logic [31:0] z, z_function_out;
    logic [7:0]  status;

    int checks = 0;
    int errors = 0;

    logic [31:0] p1a, p1b, ez = '0, mz;
    logic [2:0]  p1r;
    logic        p1v = 1'b0;
    logic [7:0]  est = '0, ms;

    fp_mult_top dut (
        .clk            (clk),
        .rst            (rst),
        .a              (a),
        .b              (b),
        .round          (round),
        .z              (z),
        .status         (status),
        .z_function_out (z_function_out)
    );

    always #5 clk = ~clk;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Exact integer product, then rounding by comparing the discarded remainder to one half.
    function automatic void ref_model(input logic [31:0] x, input logic [31:0] y,
                                      input logic [2:0] mode,
                                      output logic [31:0] rz, output logic [7:0] rs);
        int ex, ey, md, sh, e;
        logic s, xz, yz, xi, yi, xn, yn, up, inexact, to_inf, to_min;
        logic [23:0] ma, mb;
        longint unsigned mm, q, rem, half;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        md = (mode > 3'd5) ? 0 : int'(mode);
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        rs = 8'h00;
        if (xn || yn || (xi && yz) || (yi && xz)) begin
            rz = 32'h7FC00000; rs = 8'h04; return;
        end
        if (xi || yi) begin
            rz = {s, 8'hFF, 23'd0}; rs = 8'h02; return;
        end
        if (xz || yz) begin
            rz = {s, 31'd0}; rs = 8'h01; return;
        end
        ma   = {1'b1, x[22:0]};
        mb   = {1'b1, y[22:0]};
        mm   = 64'(ma) * 64'(mb);
        sh   = (mm >= (64'd1 << 47)) ? 24 : 23;
        q    = mm >> sh;
        rem  = mm - (q << sh);
        half = 64'd1 << (sh - 1);
        e    = ex + ey - 127 + (sh - 23);
        inexact = (rem != 0);
        case (md)
            0:       up = (rem > half) || ((rem == half) && q[0]);
            1:       up = 1'b0;
            2:       up = !s && inexact;
            3:       up = s && inexact;
            4:       up = (rem > half) || ((rem == half) && !s);
            default: up = inexact;
        endcase
        if (up) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            to_inf = (md == 0) || (md == 4) || (md == 5) || (md == 2 && !s) || (md == 3 && s);
            rz = to_inf ? {s, 8'hFF, 23'd0} : {s, 31'h7F7FFFFF};
            rs = to_inf ? 8'h32 : 8'h30;
            return;
        end
        if (e <= 0) begin
            to_min = (md == 5) || (md == 2 && !s) || (md == 3 && s);
            rz = to_min ? {s, 31'h00800000} : {s, 31'd0};
            rs = to_min ? 8'h28 : 8'h29;
            return;
        end
        rz = {s, e[7:0], q[22:0]};
        rs = inexact ? 8'h20 : 8'h00;
    endfunction

    // Expected outputs two edges behind the inputs; reset clears everything in flight.
    always @(posedge clk) begin
        if (rst) begin
            p1v <= 1'b0;
            ez  <= '0;
            est <= '0;
        end else begin
            if (p1v) begin
                ref_model(p1a, p1b, p1r, mz, ms);
                ez  <= mz;
                est <= ms;
            end else begin
                ez  <= '0;
                est <= '0;
            end
            p1v <= 1'b1;
            p1a <= a;
            p1b <= b;
            p1r <= round;
        end
    end

    always @(negedge clk) begin
        check32("z_vs_model", z, ez);
        check32("status_vs_model", {24'd0, status}, {24'd0, est});
        check32("zfunc_vs_model", z_function_out, ez);
    end

    function automatic logic [31:0] rand_op();
        logic       sg;
        logic [7:0] ex;
        sg = 1'($urandom);
        case ($urandom_range(0, 15))
            0:       return {sg, 8'h00, 23'($urandom)};
            1:       return {sg, 8'hFF, 23'd0};
            2:       return {sg, 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
            3:       begin ex = 8'($urandom_range(1, 20));    return {sg, ex, 23'($urandom)}; end
            4:       begin ex = 8'($urandom_range(235, 254)); return {sg, ex, 23'($urandom)}; end
            5, 6:    return {sg, 31'h3FC00000};
            7, 8:    begin ex = 8'($urandom_range(110, 145)); return {sg, ex, 8'($urandom), 14'd0, 1'b1}; end
            default: begin ex = 8'($urandom_range(90, 165)); return {sg, ex, 23'($urandom)}; end
        endcase
    endfunction

    task automatic do_vec(input string nm, input logic [31:0] va, input logic [31:0] vb,
                          input logic [2:0] md, input logic [31:0] xz, input logic [7:0] xs);
        a = va;
        b = vb;
        round = round_values'(md);
        @(negedge clk);
        @(negedge clk);
        check32({nm, "_z"}, z, xz);
        check32({nm, "_status"}, {24'd0, status}, {24'd0, xs});
        check32({nm, "_zfunc"}, z_function_out, xz);
    endtask

    initial begin
        logic [31:0] tz;
        logic [7:0]  ts;

        rst   = 1'b1;
        a     = $urandom;
        b     = $urandom;
        round = IEEE_near;

        ref_model(32'h3F800001, 32'h3F800001, 3'd2, tz, ts);
        check32("model_pin_pinf", {ts, tz[23:0]}, {8'h20, 24'h800003});
        ref_model(32'h7F000000, 32'h7F000000, 3'd0, tz, ts);
        check32("model_pin_ovf", tz, 32'h7F800000);
        ref_model(32'hBF800001, 32'h3FC00000, 3'd4, tz, ts);
        check32("model_pin_tie_up_neg", tz, 32'hBFC00001);
        ref_model(32'h00800000, 32'h00800000, 3'd0, tz, ts);
        check32("model_pin_unf", {24'd0, ts}, 32'h29);

        @(negedge clk);
        check32("reset_z", z, 32'd0);
        check32("reset_status", {24'd0, status}, 32'd0);
        a = $urandom;
        b = $urandom;
        @(negedge clk);
        check32("reset_z2", z, 32'd0);
        check32("reset_zfunc", z_function_out, 32'd0);

        rst   = 1'b0;
        a     = 32'h3FC00000;
        b     = 32'h40000000;
        round = IEEE_near;
        @(negedge clk);
        check32("first_not_early_z", z, 32'd0);
        check32("first_not_early_status", {24'd0, status}, 32'd0);
        @(negedge clk);
        check32("exact_z", z, 32'h40400000);
        check32("exact_status", {24'd0, status}, 32'd0);
        check32("exact_zfunc", z_function_out, 32'h40400000);

        do_vec("rnd_near", 32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 8'h20);
        do_vec("rnd_pinf", 32'h3F800001, 32'h3F800001, 3'd2, 32'h3F800003, 8'h20);
        do_vec("rnd_zero", 32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 8'h20);
        do_vec("tie_near", 32'h3F800001, 32'h3FC00000, 3'd0, 32'h3FC00002, 8'h20);
        do_vec("tie_up_neg", 32'hBF800001, 32'h3FC00000, 3'd4, 32'hBFC00001, 8'h20);
        do_vec("tie_code7", 32'h3F800001, 32'h3FC00000, 3'd7, 32'h3FC00002, 8'h20);
        do_vec("ovf_near", 32'h7F000000, 32'h7F000000, 3'd0, 32'h7F800000, 8'h32);
        do_vec("ovf_zero", 32'h7F000000, 32'h7F000000, 3'd1, 32'h7F7FFFFF, 8'h30);
        do_vec("unf_near", 32'h00800000, 32'h00800000, 3'd0, 32'h00000000, 8'h29);
        do_vec("unf_away", 32'h00800000, 32'h00800000, 3'd5, 32'h00800000, 8'h28);
        do_vec("inf_x_zero", 32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 8'h04);

        for (int m = 0; m < 8; m++) begin
            for (int i = 0; i < 32; i++) begin
                a = rand_op();
                b = rand_op();
                round = round_values'(3'(m));
                @(negedge clk);
            end
        end

        a = rand_op();
        b = rand_op();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a = rand_op();
            b = rand_op();
            round = round_values'(3'($urandom_range(0, 5)));
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_mult_top.md
# fp_mult_top

Single-precision IEEE-754 floating-point multiplier with selectable rounding mode, registered inputs and outputs, and an 8-bit exception status word. It also produces a golden result from a behavioural package function on the same registered operands, for on-chip self-checking. It sits as a standalone arithmetic unit: operands in, product plus flags out two clocks later, with no handshake.

## Interface
- No parameters.
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  32  operand A, IEEE-754 binary32.
- b  in  32  operand B, IEEE-754 binary32.
- round  in  round_values (3)  rounding mode, from round_enum_pkg.
- z  out  32  rounded product.
- status  out  8  exception flags, aligned with z.
- z_function_out  out  32  behavioural reference product, aligned with z.

## Operation
- Rounding modes, round_values encoding:
  - IEEE_near=0: nearest, ties to even.
  - IEEE_zero=1: toward zero.
  - IEEE_pinf=2: toward +inf.
  - IEEE_ninf=3: toward -inf.
  - near_up=4: nearest, ties toward +inf.
  - away_zero=5: away from zero whenever inexact.
  - Codes 6 and 7 behave as IEEE_near.
- Datapath:
  - Sign is a[31]^b[31].
  - Exponent is ea+eb-127 (10-bit signed intermediate).
  - Mantissa is the 24x24 product of hidden-bit mantissas, 48 bits.
  - Normalize: if P[47] is set, shift right 1 and exponent +1.
  - Round using the 23-bit fraction, guard bit and sticky (OR of remaining bits).
  - Renormalize if rounding carries out (exponent +1).
- Input classes: exp=0 is zero (denormals flushed to zero); exp=255 with frac=0 is inf; exp=255 with frac≠0 is NaN.
- Specials, which override the datapath:
  - NaN × anything, or inf × 0: result 0x7FC00000, nan flag.
  - inf × finite-nonzero, or inf × inf: result signed inf, inf flag.
  - 0 × finite: result signed zero, zero flag.
- Overflow, final exponent ≥ 255: huge and inexact flags are set.
  - Result is signed inf when the mode rounds away from the max-normal magnitude: near, near_up, away_zero, pinf for +, ninf for −.
  - Otherwise the result is signed max normal (0x7F7FFFFF magnitude).
  - When the result is inf, the inf flag is also set.
- Underflow, final exponent ≤ 0: tiny and inexact flags are set.
  - Result is signed min normal (0x00800000 magnitude) for away_zero, pinf with +, and ninf with −.
  - Otherwise the result is signed zero and the zero flag is also set.
- status bits: [0] zero, [1] inf, [2] nan, [3] tiny, [4] huge, [5] inexact, [7:6] always 0.
  - inexact = guard|sticky for a normal result.
- z_function_out is the package function fp_mult_ref(a_r, b_r, round_r). It is a behavioural, non-synthesis-critical model computing the same spec. It must equal z for every input.

## Timing
- Stage 1: a, b and round are registered into a_r, b_r, round_r on the rising edge.
- The combinational multiply, round and exception logic runs from stage 1.
- Stage 2: z, status and z_function_out are registered.
- Latency is exactly 2 clocks: inputs sampled at edge n appear on outputs after edge n+1.
- Throughput is one operation per clock, with no stall or valid signal.
- Reset: while rst=1 at an edge, all stage-1 and stage-2 registers load 0, so z=0, status=0 and z_function_out=0.
- Reset mid-stream discards in-flight operations.
- After deassertion, the first valid output appears 2 edges after the first sampled input. Before that, outputs are 0.

## Structure
- round_enum_pkg holds:
  - the round_values typedef enum logic [2:0];
  - status bit index constants;
  - bias (127), canonical NaN, and max-normal/min-normal constants;
  - the fp_mult_ref function.
- A natural sub-module is fp_round: it takes sign, 24-bit mantissa, guard, sticky, exponent and mode, and returns the rounded mantissa/exponent plus inexact.
- fp_mult_top holds the registers, mantissa product, normalization and exception muxing.

## Test plan
- Reset:
  - Hold rst=1 for 2 clocks with random a/b -> z=0, status=0.
  - Release rst -> first result exactly 2 edges after stimulus.
- Exact product: 0x3FC00000 × 0x40000000, IEEE_near -> z=0x40400000, status=0x00, z_function_out=z.
- Rounding: 0x3F800001 × 0x3F800001 -> status=0x20 in each mode:
  - IEEE_near -> z=0x3F800002.
  - IEEE_pinf -> z=0x3F800003.
  - IEEE_zero -> z=0x3F800002.
- Overflow: 0x7F000000 × 0x7F000000:
  - IEEE_near -> z=0x7F800000, status=0x32.
  - IEEE_zero -> z=0x7F7FFFFF, status=0x30.
- Underflow and specials:
  - 0x00800000 × 0x00800000, IEEE_near -> z=0x00000000, status=0x29.
  - 0x7F800000 × 0x00000000 -> z=0x7FC00000, status=0x04.
- Back-to-back: 8 consecutive random pairs, one per clock, in all six modes -> z==z_function_out each cycle, with correct 2-cycle alignment.
